im_load_arb: RTL

IM_LOAD_ARB -- requirements
Module: im_load_arb

---
 rtl/im_load_arb_pkg.sv | 16 +
 rtl/im_load_arb.sv | 135 +++++++++++++
 2 files changed

// File: rtl/im_load_arb_pkg.sv
// Shared definitions for the instruction-memory loader/CPU arbiter:
// address/data widths and the loader state encoding.
package im_load_arb_pkg;

    localparam int unsigned IM_AW = 14;
    localparam int unsigned IM_DW = 16;
    localparam int unsigned CNT_W = IM_AW + 1;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_HI   = 2'd1,
        LD_LO   = 2'd2,
        LD_WR   = 2'd3
    } ld_state_e;

endpackage

// File: rtl/im_load_arb.sv
// Instruction memory port arbiter: the CPU fetches through combinationally in IDLE,
// a byte-stream loader takes over the port to write LOAD_WORDS big-endian 16-bit words.
module im_load_arb
    import im_load_arb_pkg::*;
#(
    parameter int unsigned LOAD_WORDS = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IM_AW-1:0] cpu_addr,
    input  logic             cpu_rd_en,
    output logic             cpu_stall,
    input  logic             ld_start,
    input  logic [7:0]       ld_byte,
    input  logic             ld_vld,
    output logic             ld_busy,
    output logic             ld_done,
    output logic [IM_AW-1:0] im_addr,
    output logic             im_rd_en,
    output logic             im_we,
    output logic [IM_DW-1:0] im_wdata
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_WORDS - 1);

    ld_state_e        state_q, state_d;
    logic [IM_AW-1:0] addr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IM_DW-1:0] wdata_q;
    logic             done_q;
    logic             busy_q;
    logic             we_q;

    logic             clr;
    logic             inc;
    logic             latch_hi;
    logic             latch_lo;
    logic             last_wr;

    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        inc      = 1'b0;
        latch_hi = 1'b0;
        latch_lo = 1'b0;
        last_wr  = 1'b0;
        // ld_start has priority in every state, so a byte arriving with it is dropped
        unique case (state_q)
            LD_IDLE: begin
                if (ld_start) begin
                    state_d = LD_HI;
                    clr     = 1'b1;
                end
            end
            LD_HI: begin
                if (ld_start) begin
                    state_d = LD_HI;
                    clr     = 1'b1;
                end else if (ld_vld) begin
                    state_d  = LD_LO;
                    latch_hi = 1'b1;
                end
            end
            LD_LO: begin
                if (ld_start) begin
                    state_d = LD_HI;
                    clr     = 1'b1;
                end else if (ld_vld) begin
                    state_d  = LD_WR;
                    latch_lo = 1'b1;
                end
            end
            LD_WR: begin
                if (ld_start) begin
                    state_d = LD_HI;
                    clr     = 1'b1;
                end else begin
                    inc = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = LD_IDLE;
                        last_wr = 1'b1;
                    end else begin
                        state_d = LD_HI;
                    end
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last_wr;
            // Strobes are flopped from the next state so they never glitch
            busy_q  <= (state_d != LD_IDLE);
            we_q    <= (state_d == LD_WR);
            if (clr) begin
                addr_q  <= '0;
                cnt_q   <= '0;
                wdata_q <= '0;
            end else begin
                if (inc) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!last_wr) begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                if (latch_hi) begin
                    wdata_q[15:8] <= ld_byte;
                end
                if (latch_lo) begin
                    wdata_q[7:0] <= ld_byte;
                end
            end
        end
    end

    assign cpu_stall = busy_q;
    assign ld_busy   = busy_q;
    assign ld_done   = done_q;
    assign im_we     = we_q;
    assign im_wdata  = wdata_q;
    assign im_addr   = busy_q ? addr_q : cpu_addr;
    assign im_rd_en  = cpu_rd_en & ~busy_q;

endmodule
